win_avg_slide: RTL and testbench



---
 rtl/win_avg_pkg.sv | 20 ++
 rtl/win_avg_hist.sv | 41 ++++
 rtl/win_avg_slide.sv | 140 ++++++++++++++
 tb/tb_win_avg_slide.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/win_avg_pkg.sv
// Shared types and width helper for the windowed moving-average block.
package win_avg_pkg;

  typedef enum logic [1:0] {
    FLUSH,
    FILL,
    STEADY
  } state_t;

  typedef enum logic {
    SLIDING,
    BLOCK
  } mode_t;

  // A sum of 2^max_win_log2 samples needs max_win_log2 extra bits of headroom.
  function automatic int acc_w(input int bits, input int max_win_log2);
    return bits + max_win_log2;
  endfunction

endpackage

// File: rtl/win_avg_hist.sv
// Sample history ring buffer: one write per accepted beat, combinational read
// of the sample written 'delay' beats ago.
module win_avg_hist
  import win_avg_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] delay,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr;

  // A delay of the full depth wraps to wptr itself, which still holds the
  // oldest sample until the write at the end of this cycle.
  assign rd_data = mem[wptr - delay];

  always_ff @(posedge aclk) begin
    if (!aresetn || clr) begin
      wptr <= '0;
    end else if (wr_en) begin
      wptr <= wptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are always written before
  // the window logic ever reads them, and a reset here would block RAM mapping.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wptr] <= wr_data;
    end
  end

endmodule

// File: rtl/win_avg_slide.sv
// Per-channel moving-window sum/average over STREAMS signed channels with a
// runtime power-of-two window, sliding or block mode, and AXI-Stream handshakes.
module win_avg_slide
  import win_avg_pkg::*;
#(
  parameter int STREAMS      = 16,
  parameter int BITS         = 32,
  parameter int MAX_WIN_LOG2 = 5
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [$clog2(MAX_WIN_LOG2+1)-1:0]    win_log2,
  input  logic                                 mode,
  input  logic                                 avg_en,
  input  logic [BITS*STREAMS-1:0]              axis_di,
  input  logic                                 axis_vi,
  output logic                                 axis_ri,
  output logic [2*BITS*STREAMS-1:0]            axis_do,
  output logic                                 axis_vo,
  input  logic                                 axis_ro
);

  localparam int AW  = acc_w(BITS, MAX_WIN_LOG2);
  localparam int WLW = $clog2(MAX_WIN_LOG2 + 1);
  localparam int CW  = MAX_WIN_LOG2 + 1;
  localparam logic [WLW-1:0] MAX_W = WLW'(MAX_WIN_LOG2);

  state_t                  state;
  logic [WLW-1:0]          win_q;
  logic [WLW-1:0]          win_in;
  mode_t                   mode_q;
  mode_t                   mode_in;
  logic                    avg_q;
  logic [CW-1:0]           fill_cnt;
  logic [CW-1:0]           win_len;
  logic signed [AW-1:0]    acc     [STREAMS];
  logic signed [AW-1:0]    acc_nxt [STREAMS];
  logic [2*BITS*STREAMS-1:0] res;
  logic [BITS*STREAMS-1:0] old_beat;
  logic                    accept;
  logic                    emit;
  logic                    cfg_chg;
  logic                    last_fill;

  assign win_in    = (win_log2 > MAX_W) ? MAX_W : win_log2;
  assign mode_in   = mode ? BLOCK : SLIDING;
  assign cfg_chg   = (win_in != win_q) || (mode_in != mode_q);
  assign win_len   = CW'(1) << win_q;
  assign last_fill = (fill_cnt + CW'(1)) == win_len;

  assign axis_ri = aresetn && (state != FLUSH) && (axis_ro || !axis_vo);
  assign accept  = axis_vi && axis_ri;
  // A beat arriving together with a reconfiguration is dropped: the window it
  // would join is discarded by the flush anyway.
  assign emit    = accept && !cfg_chg &&
                   ((state == STEADY) || ((state == FILL) && last_fill));

  win_avg_hist #(
    .WIDTH      (BITS*STREAMS),
    .DEPTH_LOG2 (MAX_WIN_LOG2)
  ) u_hist (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (state == FLUSH),
    .wr_en   (accept && !cfg_chg),
    .wr_data (axis_di),
    .delay   (win_len[MAX_WIN_LOG2-1:0]),
    .rd_data (old_beat)
  );

  for (genvar i = 0; i < STREAMS; i++) begin : g_ch
    logic signed [AW-1:0] x_new;
    logic signed [AW-1:0] x_old;
    logic signed [AW-1:0] avg;

    assign x_new = {{MAX_WIN_LOG2{axis_di[i*BITS+BITS-1]}}, axis_di[i*BITS +: BITS]};
    assign x_old = {{MAX_WIN_LOG2{old_beat[i*BITS+BITS-1]}}, old_beat[i*BITS +: BITS]};
    assign acc_nxt[i] = (state == STEADY) ? acc[i] + x_new - x_old : acc[i] + x_new;
    // Arithmetic shift floors toward -inf for negative sums.
    assign avg = avg_q ? (acc_nxt[i] >>> win_q) : acc_nxt[i];
    assign res[i*2*BITS +: 2*BITS] = {{(2*BITS-AW){avg[AW-1]}}, avg};
  end

  // NOTE: all state here updates with non-blocking assignments so every
  // branch sees the pre-edge values of state, acc and fill_cnt.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= FILL;
      win_q    <= win_in;
      mode_q   <= mode_in;
      avg_q    <= avg_en;
      fill_cnt <= '0;
      axis_vo  <= 1'b0;
      axis_do  <= '0;
      for (int i = 0; i < STREAMS; i++) acc[i] <= '0;
    end else begin
      win_q  <= win_in;
      mode_q <= mode_in;
      avg_q  <= avg_en;

      if (emit) begin
        axis_do <= res;
        axis_vo <= 1'b1;
      end else if (axis_ro) begin
        axis_vo <= 1'b0;
      end

      if (cfg_chg) begin
        state <= FLUSH;
      end else begin
        case (state)
          FLUSH: begin
            state    <= FILL;
            fill_cnt <= '0;
            for (int i = 0; i < STREAMS; i++) acc[i] <= '0;
          end
          FILL: begin
            if (accept) begin
              if (!last_fill) begin
                acc      <= acc_nxt;
                fill_cnt <= fill_cnt + CW'(1);
              end else if (mode_q == BLOCK) begin
                fill_cnt <= '0;
                for (int i = 0; i < STREAMS; i++) acc[i] <= '0;
              end else begin
                acc   <= acc_nxt;
                state <= STEADY;
              end
            end
          end
          STEADY: begin
            if (accept) acc <= acc_nxt;
          end
          default: state <= FLUSH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_win_avg_slide.sv
// Directed bench for win_avg_slide: channel i carries v + 8*i, so expected
// averages step by 8 per channel and raw sums by 8*window.
module tb_win_avg_slide;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [2:0]    win_log2;
  logic          mode;
  logic          avg_en;
  logic [511:0]  axis_di;
  logic          axis_vi;
  logic          axis_ri;
  logic [1023:0] axis_do;
  logic          axis_vo;
  logic          axis_ro;

  int n_checks = 0;
  int n_err    = 0;

  win_avg_slide dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .win_log2 (win_log2),
    .mode     (mode),
    .avg_en   (avg_en),
    .axis_di  (axis_di),
    .axis_vi  (axis_vi),
    .axis_ri  (axis_ri),
    .axis_do  (axis_do),
    .axis_vo  (axis_vo),
    .axis_ro  (axis_ro)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic logic [511:0] mk_in(input int v);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'(v + 8*i);
    return b;
  endfunction

  function automatic logic [1023:0] mk_out(input longint v, input longint step);
    logic [1023:0] b;
    for (int i = 0; i < 16; i++) b[i*64 +: 64] = 64'(v + step*longint'(i));
    return b;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b required %b", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    int ch;
    ch = 0;
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      for (int c = 15; c >= 0; c--) if (got[c*64 +: 64] !== exp[c*64 +: 64]) ch = c;
      $error("FAIL %s: channel %0d observed %h required %h", tag, ch, got[ch*64 +: 64], exp[ch*64 +: 64]);
    end
  endtask

  task automatic push(input int v);
    axis_di = mk_in(v);
    axis_vi = 1'b1;
    tick();
    axis_vi = 1'b0;
  endtask

  initial begin
    aresetn  = 1'b0;
    win_log2 = 3'd2;
    mode     = 1'b0;
    avg_en   = 1'b1;
    axis_di  = '0;
    axis_vi  = 1'b0;
    axis_ro  = 1'b1;
    tick();
    tick();
    check_bit("rst_vo", axis_vo, 1'b0);
    check_beat("rst_do", axis_do, '0);
    check_bit("rst_ri", axis_ri, 1'b0);
    aresetn = 1'b1;
    #1;
    check_bit("rel_ri", axis_ri, 1'b1);

    // 1: sliding, window 4, average
    push(4);  check_bit("t1_vo1", axis_vo, 1'b0);
    push(8);  check_bit("t1_vo2", axis_vo, 1'b0);
    push(12); check_bit("t1_vo3", axis_vo, 1'b0);
    push(16); check_bit("t1_vo4", axis_vo, 1'b1);
    check_beat("t1_avg10", axis_do, mk_out(10, 8));
    push(20); check_bit("t1_vo5", axis_vo, 1'b1);
    check_beat("t1_avg14", axis_do, mk_out(14, 8));
    tick();   check_bit("t1_idle", axis_vo, 1'b0);

    // 2: block, window 2
    win_log2 = 3'd1;
    mode     = 1'b1;
    tick();   check_bit("t2_flush_ri", axis_ri, 1'b0);
    tick();   check_bit("t2_fill_ri", axis_ri, 1'b1);
    push(1);  check_bit("t2_vo1", axis_vo, 1'b0);
    push(3);  check_bit("t2_vo2", axis_vo, 1'b1);
    check_beat("t2_avg2", axis_do, mk_out(2, 8));
    push(5);  check_bit("t2_vo3", axis_vo, 1'b0);
    push(7);  check_bit("t2_vo4", axis_vo, 1'b1);
    check_beat("t2_avg6", axis_do, mk_out(6, 8));
    tick();

    // 3: sliding, window 2, negative floor and raw sum
    mode = 1'b0;
    tick();
    tick();
    push(-1); check_bit("t3_vo1", axis_vo, 1'b0);
    push(-2); check_bit("t3_vo2", axis_vo, 1'b1);
    check_beat("t3_avg_m2", axis_do, mk_out(-2, 8));
    avg_en = 1'b0;
    tick();
    push(-1); check_bit("t3_vo3", axis_vo, 1'b1);
    check_beat("t3_sum_m3", axis_do, mk_out(-3, 16));
    check_beat("t3_sext", {960'd0, axis_do[63:0]}, {960'd0, 64'hFFFF_FFFF_FFFF_FFFD});
    tick();

    // 4: backpressure, window 4 sliding average
    avg_en   = 1'b1;
    win_log2 = 3'd2;
    tick();
    tick();
    push(4);
    push(8);
    push(12);
    push(16);
    check_beat("t4_first", axis_do, mk_out(10, 8));
    axis_ro = 1'b0;
    axis_di = mk_in(20);
    axis_vi = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_bit("t4_hold_vo", axis_vo, 1'b1);
      check_beat("t4_hold_do", axis_do, mk_out(10, 8));
      check_bit("t4_hold_ri", axis_ri, 1'b0);
      tick();
    end
    axis_ro = 1'b1;
    tick();
    check_bit("t4_rel_vo", axis_vo, 1'b1);
    check_beat("t4_rel_14", axis_do, mk_out(14, 8));
    axis_vi = 1'b0;
    push(24);
    check_beat("t4_next_18", axis_do, mk_out(18, 8));

    // 6: reset mid-STEADY
    push(28);
    check_beat("t6_pre_22", axis_do, mk_out(22, 8));
    aresetn = 1'b0;
    tick();
    check_bit("t6_rst_vo", axis_vo, 1'b0);
    check_beat("t6_rst_do", axis_do, '0);
    aresetn = 1'b1;
    push(1);  check_bit("t6_vo1", axis_vo, 1'b0);
    push(2);  check_bit("t6_vo2", axis_vo, 1'b0);
    push(3);  check_bit("t6_vo3", axis_vo, 1'b0);
    push(4);  check_bit("t6_vo4", axis_vo, 1'b1);
    check_beat("t6_avg2", axis_do, mk_out(2, 8));

    // 5: reconfigure from a partial window of 4 to a window of 1
    mode = 1'b1;
    tick();
    tick();
    push(1);
    push(2);  check_bit("t5_partial_vo", axis_vo, 1'b0);
    win_log2 = 3'd0;
    tick();   check_bit("t5_flush_ri", axis_ri, 1'b0);
    tick();   check_bit("t5_fill_ri", axis_ri, 1'b1);
    push(9);  check_bit("t5_vo9", axis_vo, 1'b1);
    check_beat("t5_blk9", axis_do, mk_out(9, 8));
    push(-5); check_beat("t5_blk_m5", axis_do, mk_out(-5, 8));
    mode = 1'b0;
    tick();
    tick();
    push(7);  check_beat("t5_sl7", axis_do, mk_out(7, 8));
    push(3);  check_beat("t5_sl3", axis_do, mk_out(3, 8));
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
